// File: rtl/skel_pkg.sv
// ============================================================================
// Module      : skel_pkg
// Description : Shared types and constants for the frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skel_pkg;

    localparam int PIX_W     = 8;
    localparam int PAYLOAD_W = PIX_W + 2;

    localparam logic [PIX_W-1:0] BIN_HIGH = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } reader_state_e;

endpackage

`default_nettype wire

// File: rtl/pixel_skid_buffer.sv
// ============================================================================
// Module      : pixel_skid_buffer
// Description : Two-entry FIFO for returned pixels {data, row_end, last}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_skid_buffer
    import skel_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    input  logic                 pop,
    output logic [PAYLOAD_W-1:0] head_data,
    output logic                 head_valid,
    output logic [1:0]           count
);

    logic [PAYLOAD_W-1:0] slot0_q, slot0_d;
    logic [PAYLOAD_W-1:0] slot1_q, slot1_d;
    logic [1:0]           count_q, count_d;
    logic                 do_pop;
    logic                 do_push;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = 2'd0;
        end else begin
            // Pop first so a simultaneous push lands in the slot freed by it.
            if (do_pop) begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            if (do_push) begin
                if (count_d == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_data  = slot0_q;
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;

endmodule

`default_nettype wire

// File: rtl/frame_reader.sv
// ============================================================================
// Module      : frame_reader
// Description : Streams an N*N frame from image RAM in raster order with
//               valid/ready flow control. Optional FRAME_READER_BINARIZE_EN
//               maps every nonzero pixel to 8'hFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_reader
    import skel_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [bitSize:0] rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_row_end,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int            AW        = bitSize + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(N - 1);

    reader_state_e state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic [AW-1:0] col_q, col_d;
    logic          inflight_q, inflight_d;
    logic          pend_row_end_q, pend_row_end_d;
    logic          pend_last_q, pend_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [PAYLOAD_W-1:0] w_head;
    logic                 w_fifo_valid;
    logic [1:0]           w_fifo_count;
    logic [PIX_W-1:0]     w_pix;
    logic [2:0]           w_occ;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_flush;
    logic                 w_issue;

`ifdef FRAME_READER_BINARIZE_EN
    assign w_pix = (rd_data != '0) ? BIN_HIGH : '0;
`else
    assign w_pix = rd_data;
`endif

    assign w_pop   = w_fifo_valid && out_ready;
    assign w_flush = abort && (state_q != ST_IDLE);
    assign w_push  = inflight_q && !w_flush;
    // Occupancy net of this cycle's pop keeps one beat per cycle sustainable.
    assign w_occ   = {1'b0, w_fifo_count} - {2'b00, w_pop} + {2'b00, inflight_q};
    assign w_issue = (state_q == ST_STREAM) && !abort && (w_occ < 3'd2);

    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        next_addr_d    = next_addr_q;
        col_d          = col_q;
        inflight_d     = 1'b0;
        pend_row_end_d = pend_row_end_q;
        pend_last_d    = pend_last_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_STREAM;
                    busy_d      = 1'b1;
                    next_addr_d = '0;
                    col_d       = '0;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    rd_addr_d = '0;
                end else if (w_issue) begin
                    rd_addr_d      = next_addr_q;
                    inflight_d     = 1'b1;
                    pend_row_end_d = (col_q == LAST_COL);
                    pend_last_d    = (next_addr_q == LAST_ADDR);
                    next_addr_d    = next_addr_q + 1'b1;
                    col_d          = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                    if (next_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    rd_addr_d = '0;
                end else if (w_pop && w_head[0]) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rd_addr_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                rd_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rd_addr_q      <= '0;
            next_addr_q    <= '0;
            col_q          <= '0;
            inflight_q     <= 1'b0;
            pend_row_end_q <= 1'b0;
            pend_last_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            next_addr_q    <= next_addr_d;
            col_q          <= col_d;
            inflight_q     <= inflight_d;
            pend_row_end_q <= pend_row_end_d;
            pend_last_q    <= pend_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    pixel_skid_buffer u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (w_flush),
        .push       (w_push),
        .push_data  ({w_pix, pend_row_end_q, pend_last_q}),
        .pop        (w_pop),
        .head_data  (w_head),
        .head_valid (w_fifo_valid),
        .count      (w_fifo_count)
    );

    assign rd_addr     = rd_addr_q;
    assign out_data    = w_head[PAYLOAD_W-1:2];
    assign out_row_end = w_head[1];
    assign out_last    = w_head[0];
    assign out_valid   = w_fifo_valid;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_reader.sv
// ============================================================================
// Module      : tb_frame_reader
// Description : Scoreboard bench for frame_reader (N=8) with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_reader;

    localparam int N     = 8;
    localparam int BS    = 6;
    localparam int NPIX  = N * N;
    localparam int DEPTH = 1 << (BS + 1);

    typedef struct packed {
        logic [7:0] data;
        logic       row_end;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [BS:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_row_end;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [7:0] mem [DEPTH];
    beat_t      exp_q[$];

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int base_acc = 0;
    int done_cnt = 0;
    int base_done = 0;
    int ready_mode = 0;
    bit force_low = 1'b0;
    bit quiet = 1'b0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    frame_reader #(.N(N), .bitSize(BS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_end (out_row_end),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected beat i derived straight from the stored frame.
    function automatic beat_t model(input int i);
        beat_t b;
        logic [7:0] p;
        p = mem[i];
`ifdef FRAME_READER_BINARIZE_EN
        p = (p != 8'd0) ? 8'hFF : 8'h00;
`endif
        b.data    = p;
        b.row_end = ((i % N) == N - 1);
        b.last    = (i == NPIX - 1);
        return b;
    endfunction

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(model(i));
    endtask

    task automatic pulse_start();
        base_acc  = acc_cnt;
        base_done = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        int cyc;
        cyc = 0;
        while ((acc_cnt - base_acc) < n && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (cyc >= 2000) chk("wait_beats_timeout", acc_cnt - base_acc, n);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (done_cnt == base_done && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (cyc >= 2000) chk("frame_timeout", 0, 1);
        chk("queue_empty", exp_q.size(), 0);
        repeat (4) tick();
        chk("single_done", done_cnt - base_done, 1);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endtask

    // Monitor: drives out_ready at negedge and scores the beat the next posedge accepts.
    task automatic monitor();
        beat_t held;
        beat_t act;
        beat_t e;
        bit    held_v;
        bit    done_exp;
        held_v   = 1'b0;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (force_low) out_ready = 1'b0;
            else if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = !out_ready;
            else out_ready = ($urandom_range(0, 3) != 0);
            if (rst_n && done) done_cnt++;
            if (quiet || !rst_n) begin
                held_v   = 1'b0;
                done_exp = 1'b0;
            end else begin
                act = {out_data, out_row_end, out_last};
                chk("done_pulse", done, done_exp);
                done_exp = 1'b0;
                if (done) chk("busy_low_at_done", busy, 0);
                if (held_v) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_hold", act, held);
                end
                if (out_valid && busy)
                    chk("outstanding_le2", (int'(rd_addr) + 1 - (acc_cnt - base_acc)) <= 2, 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", act.data, e.data);
                        chk("beat_row_end", act.row_end, e.row_end);
                        chk("beat_last", act.last, e.last);
                        done_exp = e.last;
                    end
                    acc_cnt++;
                    held_v = 1'b0;
                end else if (out_valid) begin
                    held_v = 1'b1;
                    held   = act;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Frame 1: ready held high, ramp data, latency and sustained rate.
        ready_mode = 0;
        push_frame();
        pulse_start();
        chk("busy_rise", busy, 1);
        lat = 0;
        while (!out_valid && lat < 3) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", out_valid, 1);
        repeat (NPIX + 1) tick();
        chk("sustained_rate_done", done_cnt - base_done, 1);
        wait_done();

        // Frame 2: ready toggling.
        ready_mode = 1;
        push_frame();
        pulse_start();
        wait_done();

        // Frame 3: ten-cycle stall at beat 20.
        ready_mode = 0;
        push_frame();
        pulse_start();
        wait_acc(20);
        force_low = 1'b1;
        repeat (10) tick();
        force_low = 1'b0;
        wait_done();

        // Frame 4: start re-pulsed mid-frame must be ignored.
        push_frame();
        pulse_start();
        wait_acc(30);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();

        // Frame 5: random pixels with random backpressure.
        randomize_mem();
        ready_mode = 2;
        push_frame();
        pulse_start();
        wait_done();

        // Abort at beat 40.
        push_frame();
        pulse_start();
        wait_acc(40);
        force_low = 1'b1;
        tick();
        quiet = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_addr", rd_addr, 0);
        exp_q.delete();
        repeat (5) tick();
        chk("abort_no_done", done_cnt - base_done, 0);
        quiet     = 1'b0;
        force_low = 1'b0;

        // start and abort together in IDLE: no transfer.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (4) tick();
        chk("start_abort_valid", out_valid, 0);

        // Reset at beat 40, then a fresh frame from address 0.
        ready_mode = 1;
        push_frame();
        pulse_start();
        wait_acc(40);
        force_low = 1'b1;
        tick();
        quiet = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_row_end", out_row_end, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        quiet     = 1'b0;
        force_low = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        ready_mode = 0;
        push_frame();
        pulse_start();
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter N, default 8, image side length in pixels (frame = N*N pixels).
REQ-002 Parameter bitSize, default 6, address MSB index; address width bitSize+1, SHALL satisfy 2^(bitSize+1) >= N*N.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to stream the stored frame.
REQ-006 abort  in  1  synchronous cancel of an active transfer.
REQ-007 rd_addr  out  bitSize+1  read address to image RAM dual read port.
REQ-008 rd_data  in  8  RAM dual-port data, valid exactly 1 cycle after rd_addr is registered.
REQ-009 out_data  out  8  pixel value to downstream consumer.
REQ-010 out_valid  out  1  out_data/out_last/out_row_end valid.
REQ-011 out_ready  in  1  consumer accepts beat when out_valid && out_ready.
REQ-012 out_row_end  out  1  beat is the last pixel of a row (column N-1).
REQ-013 out_last  out  1  beat is pixel N*N-1.
REQ-014 busy  out  1  transfer in progress.
REQ-015 done  out  1  one-cycle pulse, frame fully accepted.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on start, STREAM->DRAIN after read N*N-1 issued, DRAIN->IDLE when final beat accepted.
REQ-017 Reads SHALL be issued in raster order 0..N*N-1, one address per issue, no wrap, no repeat, no skip.
REQ-018 Read issued only when (buffered beats + reads in flight) < 2, so no returned pixel is ever dropped.
REQ-019 Returned pixels enter a 2-entry FIFO; out_valid = FIFO non-empty; head pops on out_valid && out_ready.
REQ-020 While out_valid && !out_ready, out_data/out_row_end/out_last SHALL hold stable.
REQ-021 With out_ready held 1, first out_valid no later than 3 cycles after start sampled, then one beat per cycle sustained.
REQ-022 out_row_end = 1 iff beat index mod N == N-1; out_last = 1 iff beat index == N*N-1.
REQ-023 busy rises the cycle after start sampled in IDLE, falls with done.
REQ-024 done asserts the cycle after the out_last beat is accepted, for exactly one cycle.
REQ-025 start while busy SHALL be ignored; start and abort together in IDLE: abort wins, no transfer.
REQ-026 abort in STREAM/DRAIN: return to IDLE next cycle, FIFO flushed, in-flight read discarded, out_valid 0, no done.
REQ-027 rd_addr holds last issued value when not issuing; value in IDLE is 0.

Reset
REQ-028 rst_n low: state IDLE, rd_addr 0, FIFO empty, out_valid 0, out_data 0, out_row_end 0, out_last 0, busy 0, done 0.
REQ-029 Reset mid-transfer SHALL abandon the frame; first start after release streams from address 0.

Configuration
REQ-030 Macro FRAME_READER_BINARIZE_EN defined: out_data = 8'hFF when stored pixel nonzero, else 8'h00.
REQ-031 Macro undefined: out_data = stored pixel unmodified; all timing identical either way.

Structure
REQ-032 Package skel_pkg holds PIX_W=8, the reader state enum, and the binarize constant 8'hFF.
REQ-033 FIFO implemented as sub-module pixel_skid_buffer (2 entries, 10-bit payload: data, row_end, last).

Verification (N=8, RAM preloaded mem[i]=i)
REQ-034 out_ready=1, start pulse -> 64 consecutive beats data 0..63, out_row_end on 7,15,...,63, out_last on 63, done 1 cycle later.
REQ-035 out_ready toggling 1,0,1,0 -> same 64 values in order, no duplicates/loss, data stable while stalled.
REQ-036 out_ready low 10 cycles at beat 20 -> beat 20 held, at most 2 reads outstanding, resumes with 21.
REQ-037 start re-pulsed at beat 30 -> ignored, single frame of 64 beats, single done.
REQ-038 rst_n low at beat 40 -> all outputs 0 immediately; next start streams from 0; abort at beat 40 -> out_valid 0 next cycle, no done.
REQ-039 FRAME_READER_BINARIZE_EN defined -> beat 0 = 8'h00, beats 1..63 = 8'hFF.
